// File: rtl/fsm_dispense_if.sv
// Signal bundle between the dispense controller and the seller FSM / machine I/O.
// The master drives sale pulses and sensor inputs; the slave (controller) drives actuators and status.
interface fsm_dispense_if;
    logic       sell_flag;
    logic       change_flag;
    logic       prod_sensor;
    logic       fault_clr;
    logic       motor_en;
    logic       coin_eject;
    logic       dispense_done;
    logic       busy;
    logic       q_full;
    logic       fault;
    logic       ovf;
    logic [7:0] drop_cnt;

    modport master (
        output sell_flag, change_flag, prod_sensor, fault_clr,
        input  motor_en, coin_eject, dispense_done, busy, q_full, fault, ovf, drop_cnt
    );

    modport slave (
        input  sell_flag, change_flag, prod_sensor, fault_clr,
        output motor_en, coin_eject, dispense_done, busy, q_full, fault, ovf, drop_cnt
    );
endinterface

// File: rtl/fsm_dispense.sv
// Dispense controller: queues sales, runs the product motor, confirms the drop via the
// sensor and ejects a 0.5 change coin when owed. Faults out if the product never drops.
module fsm_dispense #(
    parameter int QDEPTH       = 4,
    parameter int MOTOR_CYCLES = 8,
    parameter int EJECT_CYCLES = 4,
    parameter int TIMEOUT      = 64
) (
    input  logic            clk,
    input  logic            rst,
    fsm_dispense_if.slave   bus
);

    localparam int AW   = $clog2(QDEPTH);
    localparam int CW   = AW + 1;
    localparam int MAXC = (TIMEOUT > MOTOR_CYCLES)
                        ? ((TIMEOUT > EJECT_CYCLES) ? TIMEOUT : EJECT_CYCLES)
                        : ((MOTOR_CYCLES > EJECT_CYCLES) ? MOTOR_CYCLES : EJECT_CYCLES);
    localparam int NW   = $clog2(MAXC + 1);

    localparam logic [NW-1:0] MOTOR_LAST   = NW'(MOTOR_CYCLES - 1);
    localparam logic [NW-1:0] EJECT_LAST   = NW'(EJECT_CYCLES - 1);
    localparam logic [NW-1:0] TIMEOUT_LAST = NW'(TIMEOUT - 1);
    localparam logic [CW-1:0] QDEPTH_CNT   = CW'(QDEPTH);

    typedef enum logic [2:0] {
        IDLE,
        MOTOR,
        WAIT_DROP,
        EJECT,
        DONE,
        FAULT
    } state_t;

    state_t          state;
    logic [QDEPTH-1:0] q_mem;
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   q_count;
    logic [NW-1:0]   cyc_cnt;
    logic            chg_r;
    logic            seen_r;
    logic            motor_en_r;
    logic            coin_eject_r;
    logic            done_r;
    logic            fault_r;
    logic            ovf_r;
    logic [7:0]      drop_cnt_r;

    logic            q_full_i;
    logic            q_empty_i;
    logic            push;
    logic            pop;
    logic            dropped;

    assign q_full_i  = (q_count == QDEPTH_CNT);
    assign q_empty_i = (q_count == '0);
    assign push      = bus.sell_flag && !q_full_i;
    assign pop       = (state == IDLE) && !q_empty_i;
    assign dropped   = seen_r || bus.prod_sensor;

    // Request FIFO of change bits; a push and a pop in the same cycle leave the count unchanged.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_mem   <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            q_count <= '0;
            ovf_r   <= 1'b0;
        end else begin
            if (push) begin
                q_mem[wr_ptr] <= bus.change_flag;
                wr_ptr        <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                q_count <= q_count + CW'(1);
            end else if (pop && !push) begin
                q_count <= q_count - CW'(1);
            end
            if (bus.sell_flag && q_full_i) begin
                ovf_r <= 1'b1;
            end else if (bus.fault_clr) begin
                ovf_r <= 1'b0;
            end
        end
    end

    // Outputs are registered alongside the state so they switch on the same edge as it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cyc_cnt      <= '0;
            chg_r        <= 1'b0;
            seen_r       <= 1'b0;
            motor_en_r   <= 1'b0;
            coin_eject_r <= 1'b0;
            done_r       <= 1'b0;
            fault_r      <= 1'b0;
            drop_cnt_r   <= '0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (!q_empty_i) begin
                        chg_r      <= q_mem[rd_ptr];
                        seen_r     <= 1'b0;
                        cyc_cnt    <= '0;
                        motor_en_r <= 1'b1;
                        state      <= MOTOR;
                    end
                end

                MOTOR: begin
                    seen_r <= dropped;
                    if (cyc_cnt == MOTOR_LAST) begin
                        motor_en_r <= 1'b0;
                        cyc_cnt    <= '0;
                        if (!dropped) begin
                            state <= WAIT_DROP;
                        end else if (chg_r) begin
                            coin_eject_r <= 1'b1;
                            state        <= EJECT;
                        end else begin
                            done_r     <= 1'b1;
                            drop_cnt_r <= drop_cnt_r + 8'd1;
                            state      <= DONE;
                        end
                    end else begin
                        cyc_cnt <= cyc_cnt + NW'(1);
                    end
                end

                WAIT_DROP: begin
                    if (bus.prod_sensor) begin
                        cyc_cnt <= '0;
                        if (chg_r) begin
                            coin_eject_r <= 1'b1;
                            state        <= EJECT;
                        end else begin
                            done_r     <= 1'b1;
                            drop_cnt_r <= drop_cnt_r + 8'd1;
                            state      <= DONE;
                        end
                    end else if (cyc_cnt == TIMEOUT_LAST) begin
                        cyc_cnt <= '0;
                        fault_r <= 1'b1;
                        state   <= FAULT;
                    end else begin
                        cyc_cnt <= cyc_cnt + NW'(1);
                    end
                end

                EJECT: begin
                    if (cyc_cnt == EJECT_LAST) begin
                        coin_eject_r <= 1'b0;
                        cyc_cnt      <= '0;
                        done_r       <= 1'b1;
                        drop_cnt_r   <= drop_cnt_r + 8'd1;
                        state        <= DONE;
                    end else begin
                        cyc_cnt <= cyc_cnt + NW'(1);
                    end
                end

                DONE: begin
                    state <= IDLE;
                end

                FAULT: begin
                    // The aborted item is abandoned; queued sales resume once cleared.
                    if (bus.fault_clr) begin
                        fault_r <= 1'b0;
                        state   <= IDLE;
                    end
                end

                default: begin
                    motor_en_r   <= 1'b0;
                    coin_eject_r <= 1'b0;
                    fault_r      <= 1'b0;
                    state        <= IDLE;
                end
            endcase
        end
    end

    assign bus.motor_en      = motor_en_r;
    assign bus.coin_eject    = coin_eject_r;
    assign bus.dispense_done = done_r;
    assign bus.fault         = fault_r;
    assign bus.ovf           = ovf_r;
    assign bus.drop_cnt      = drop_cnt_r;
    assign bus.q_full        = q_full_i;
    assign bus.busy          = (state != IDLE) || !q_empty_i;

endmodule

// File: tb/tb_fsm_dispense.sv
// Directed self-checking bench for fsm_dispense with default parameters
// (QDEPTH=4, MOTOR_CYCLES=8, EJECT_CYCLES=4, TIMEOUT=64).
module tb_fsm_dispense;

    logic clk;
    logic rst;
    int   test_cnt;
    int   fail_cnt;

    fsm_dispense_if bus ();

    fsm_dispense dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: observed timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic sell, input logic chg, input logic sensor, input logic clr);
        bus.sell_flag   = sell;
        bus.change_flag = chg;
        bus.prod_sensor = sensor;
        bus.fault_clr   = clr;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        test_cnt++;
        assert (observed === expected) else begin
            fail_cnt++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
            $error("[TB] check %s differs", tag);
        end
    endtask

    task automatic applyReset();
        applyStimulus(0, 0, 0, 0);
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        int  dones;
        int  overlap;
        bit  found;

        test_cnt = 0;
        fail_cnt = 0;
        rst      = 1'b1;
        applyStimulus(0, 0, 0, 0);

        // Reset state
        applyReset();
        checkOutput("rst_motor", bus.motor_en, 0);
        checkOutput("rst_eject", bus.coin_eject, 0);
        checkOutput("rst_done", bus.dispense_done, 0);
        checkOutput("rst_busy", bus.busy, 0);
        checkOutput("rst_qfull", bus.q_full, 0);
        checkOutput("rst_fault", bus.fault, 0);
        checkOutput("rst_ovf", bus.ovf, 0);
        checkOutput("rst_dropcnt", bus.drop_cnt, 0);

        // 1: sale without change, sensor in motor cycle 3
        applyStimulus(1, 0, 0, 0);
        tick();
        applyStimulus(0, 0, 0, 0);
        checkOutput("t1_busy_T1", bus.busy, 1);
        checkOutput("t1_motor_T1", bus.motor_en, 0);
        tick();
        for (int c = 2; c <= 9; c++) begin
            checkOutput($sformatf("t1_motor_T%0d", c), bus.motor_en, 1);
            checkOutput($sformatf("t1_eject_T%0d", c), bus.coin_eject, 0);
            bus.prod_sensor = (c == 4);
            tick();
        end
        checkOutput("t1_done_T10", bus.dispense_done, 1);
        checkOutput("t1_motor_T10", bus.motor_en, 0);
        checkOutput("t1_eject_T10", bus.coin_eject, 0);
        checkOutput("t1_dropcnt", bus.drop_cnt, 1);
        tick();
        checkOutput("t1_done_T11", bus.dispense_done, 0);
        checkOutput("t1_busy_T11", bus.busy, 0);

        // 2: sale with change, sensor in the second WAIT_DROP cycle
        applyReset();
        applyStimulus(1, 1, 0, 0);
        tick();
        applyStimulus(0, 0, 0, 0);
        tick();
        for (int c = 2; c <= 9; c++) begin
            checkOutput($sformatf("t2_motor_T%0d", c), bus.motor_en, 1);
            tick();
        end
        checkOutput("t2_motor_T10", bus.motor_en, 0);
        checkOutput("t2_eject_T10", bus.coin_eject, 0);
        checkOutput("t2_busy_T10", bus.busy, 1);
        tick();
        checkOutput("t2_eject_T11", bus.coin_eject, 0);
        checkOutput("t2_done_T11", bus.dispense_done, 0);
        bus.prod_sensor = 1'b1;
        tick();
        bus.prod_sensor = 1'b0;
        for (int c = 12; c <= 15; c++) begin
            checkOutput($sformatf("t2_eject_T%0d", c), bus.coin_eject, 1);
            checkOutput($sformatf("t2_motor_T%0d", c), bus.motor_en, 0);
            tick();
        end
        checkOutput("t2_done_T16", bus.dispense_done, 1);
        checkOutput("t2_eject_T16", bus.coin_eject, 0);
        checkOutput("t2_dropcnt", bus.drop_cnt, 1);

        // 3: back-to-back sales; the first is popped at T+1, so the sixth overflows
        applyReset();
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1, 0, 1, 0);
            if (i == 4) checkOutput("t3_qfull_T4", bus.q_full, 0);
            if (i == 5) checkOutput("t3_qfull_T5", bus.q_full, 1);
            tick();
        end
        applyStimulus(0, 0, 1, 0);
        checkOutput("t3_ovf_T6", bus.ovf, 1);
        checkOutput("t3_qfull_T6", bus.q_full, 1);
        dones   = 0;
        overlap = 0;
        for (int k = 0; k < 80; k++) begin
            if (bus.dispense_done) dones++;
            if (bus.motor_en && bus.coin_eject) overlap++;
            tick();
        end
        checkOutput("t3_dones", dones, 5);
        checkOutput("t3_dropcnt", bus.drop_cnt, 5);
        checkOutput("t3_overlap", overlap, 0);
        checkOutput("t3_busy_end", bus.busy, 0);
        checkOutput("t3_ovf_sticky", bus.ovf, 1);
        applyStimulus(0, 0, 1, 1);
        tick();
        applyStimulus(0, 0, 0, 0);
        checkOutput("t3_ovf_cleared", bus.ovf, 0);
        checkOutput("t3_fault_idle", bus.fault, 0);
        checkOutput("t3_busy_clr", bus.busy, 0);

        // 4: no sensor -> fault after 8 motor + 64 wait cycles
        applyReset();
        applyStimulus(1, 0, 0, 0);
        tick();
        applyStimulus(0, 0, 0, 0);
        tick();
        for (int c = 2; c < 73; c++) tick();
        checkOutput("t4_fault_T73", bus.fault, 0);
        checkOutput("t4_motor_T73", bus.motor_en, 0);
        tick();
        checkOutput("t4_fault_T74", bus.fault, 1);
        checkOutput("t4_motor_T74", bus.motor_en, 0);
        checkOutput("t4_eject_T74", bus.coin_eject, 0);
        applyStimulus(1, 0, 0, 0);
        tick();
        applyStimulus(0, 0, 0, 0);
        checkOutput("t4_fault_T75", bus.fault, 1);
        checkOutput("t4_busy_T75", bus.busy, 1);
        tick();
        tick();
        tick();
        checkOutput("t4_fault_hold", bus.fault, 1);
        checkOutput("t4_motor_hold", bus.motor_en, 0);
        checkOutput("t4_dropcnt_hold", bus.drop_cnt, 0);
        applyStimulus(0, 0, 1, 1);
        tick();
        bus.fault_clr = 1'b0;
        checkOutput("t4_fault_clr", bus.fault, 0);
        checkOutput("t4_busy_clr", bus.busy, 1);
        tick();
        checkOutput("t4_motor_restart", bus.motor_en, 1);
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            if (bus.dispense_done) found = 1'b1;
            else tick();
        end
        checkOutput("t4_done_seen", found, 1);
        checkOutput("t4_dropcnt", bus.drop_cnt, 1);
        applyStimulus(0, 0, 0, 0);
        tick();
        tick();
        checkOutput("t4_busy_end", bus.busy, 0);

        // 5: reset during the second eject cycle aborts everything, queue included
        applyStimulus(1, 1, 1, 0);
        tick();
        applyStimulus(0, 0, 1, 0);
        tick();
        for (int c = 2; c <= 9; c++) begin
            bus.sell_flag = (c == 3);
            tick();
        end
        bus.sell_flag = 1'b0;
        checkOutput("t5_eject_T10", bus.coin_eject, 1);
        checkOutput("t5_motor_T10", bus.motor_en, 0);
        tick();
        checkOutput("t5_eject_T11", bus.coin_eject, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        applyStimulus(0, 0, 0, 0);
        checkOutput("t5_eject_rst", bus.coin_eject, 0);
        checkOutput("t5_motor_rst", bus.motor_en, 0);
        checkOutput("t5_busy_rst", bus.busy, 0);
        checkOutput("t5_dropcnt_rst", bus.drop_cnt, 0);
        tick();
        tick();
        checkOutput("t5_busy_after", bus.busy, 0);
        checkOutput("t5_motor_after", bus.motor_en, 0);

        // 6: change_flag alone is ignored; push+pop in the same IDLE cycle keeps the count
        applyReset();
        applyStimulus(0, 1, 0, 0);
        tick();
        applyStimulus(0, 0, 0, 0);
        checkOutput("t6_busy_chgonly", bus.busy, 0);
        tick();
        checkOutput("t6_busy_chgonly2", bus.busy, 0);
        checkOutput("t6_motor_chgonly", bus.motor_en, 0);
        for (int c = 0; c <= 14; c++) begin
            applyStimulus((c == 0 || c == 3 || c == 4 || c == 11 || c == 12 || c == 13), 0, 1, 0);
            if (c == 10) checkOutput("t6_done_T10", bus.dispense_done, 1);
            if (c == 11) checkOutput("t6_motor_T11", bus.motor_en, 0);
            if (c == 13) checkOutput("t6_qfull_T13", bus.q_full, 0);
            if (c == 14) checkOutput("t6_qfull_T14", bus.q_full, 1);
            tick();
        end
        applyStimulus(0, 0, 1, 0);
        found = 1'b0;
        for (int k = 0; k < 100 && !found; k++) begin
            if (!bus.busy) found = 1'b1;
            else tick();
        end
        checkOutput("t6_drained", found, 1);
        checkOutput("t6_dropcnt", bus.drop_cnt, 6);
        checkOutput("t6_ovf", bus.ovf, 0);

        $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
        $finish;
    end

endmodule
